// File: rtl/lc3b_icache_pkg.sv
// lc3b_icache_pkg
//   Shared types for the LC-3b instruction cache: word/line/tag/index/offset
//   widths, the controller state type, and a helper that picks one 16-bit
//   word out of a 128-bit line.
//   No ports (package).
package lc3b_icache_pkg;

   localparam int unsigned NUM_SETS  = 8;
   localparam int unsigned LINE_BITS = 128;

   typedef logic [15:0]          lc3b_word;
   typedef logic [LINE_BITS-1:0] lc3b_c_line;
   typedef logic [8:0]           lc3b_c_tag;
   typedef logic [2:0]           lc3b_c_index;
   typedef logic [2:0]           lc3b_c_offset;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

   // Word n of a line sits at bits [16n+15:16n].
   function automatic lc3b_word line_word(input lc3b_c_line line, input lc3b_c_offset off);
      return line[{off, 4'b0000} +: 16];
   endfunction

endpackage

// File: rtl/lc3b_icache_way.sv
// icache_way
//   Storage for one way of the instruction cache: per-set valid bit, 9-bit
//   tag and 128-bit data line. Reads are combinational by rd_index; writes
//   happen on the rising clock edge when we=1. Valid bits clear on rst_n.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     rd_index          set being looked up
//     valid/tag/data    contents of that set
//     we                install a line this cycle
//     wr_index          set being written
//     wr_tag/wr_data    tag and line to install (valid is set to 1)
module icache_way
   import lc3b_icache_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [2:0]   rd_index,
   output logic         valid,
   output logic [8:0]   tag,
   output logic [127:0] data,
   input  logic         we,
   input  logic [2:0]   wr_index,
   input  logic [8:0]   wr_tag,
   input  logic [127:0] wr_data
);

   logic [NUM_SETS-1:0] valid_q;
   lc3b_c_tag           tag_q  [NUM_SETS];
   lc3b_c_line          data_q [NUM_SETS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // Tag/data need no reset: they are only observed through a set valid bit.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_data;
      end
   end

   assign valid = valid_q[rd_index];
   assign tag   = tag_q[rd_index];
   assign data  = data_q[rd_index];

endmodule

// File: rtl/lc3b_icache.sv
// lc3b_icache
//   Read-only 2-way set-associative instruction cache (8 sets, 128-bit
//   lines). Hits answer combinationally in the request cycle; misses stall
//   fetch while the line is fetched from physical memory and installed into
//   the least-recently-used way.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     i_read         fetch request valid
//     i_address      byte address: [15:7] tag, [6:4] set, [3:1] word
//     i_rdata        instruction word (0 when not responding)
//     i_mem_resp     request satisfied this cycle
//     pmem_read      line-fill request, held for the whole fill
//     pmem_address   line address of the fill, low 4 bits zero
//     pmem_rdata     fill line, word n at [16n+15:16n]
//     pmem_resp      fill data valid (one-cycle pulse)
module lc3b_icache
   import lc3b_icache_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_read,
   input  logic [15:0]  i_address,
   output logic [15:0]  i_rdata,
   output logic         i_mem_resp,
   output logic         pmem_read,
   output logic [15:0]  pmem_address,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp
);

   icache_state_t       state;
   logic [11:0]         fill_addr;   // {tag, set} of the line being filled
   logic [NUM_SETS-1:0] lru;         // per set: way that is least recently used

   lc3b_c_tag    req_tag;
   lc3b_c_index  req_set;
   lc3b_c_offset req_word;
   lc3b_c_index  fill_set;
   lc3b_c_tag    fill_tag;

   logic         v0, v1;
   lc3b_c_tag    t0, t1;
   lc3b_c_line   d0, d1;
   logic         hit0, hit1, hit, hit_way;
   logic         fill_done, victim, we0, we1;
   logic         unused_addr_bit;

   assign req_tag         = i_address[15:7];
   assign req_set         = i_address[6:4];
   assign req_word        = i_address[3:1];
   assign unused_addr_bit = i_address[0];
   assign fill_set        = fill_addr[2:0];
   assign fill_tag        = fill_addr[11:3];

   icache_way way0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_index (req_set),
      .valid    (v0),
      .tag      (t0),
      .data     (d0),
      .we       (we0),
      .wr_index (fill_set),
      .wr_tag   (fill_tag),
      .wr_data  (pmem_rdata)
   );

   icache_way way1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_index (req_set),
      .valid    (v1),
      .tag      (t1),
      .data     (d1),
      .we       (we1),
      .wr_index (fill_set),
      .wr_tag   (fill_tag),
      .wr_data  (pmem_rdata)
   );

   assign hit0    = v0 && (t0 == req_tag);
   assign hit1    = v1 && (t1 == req_tag);
   assign hit     = (state == IDLE) && i_read && (hit0 || hit1);
   assign hit_way = !hit0;   // way 0 wins a double match

   assign fill_done = (state == FILL) && pmem_resp;
   assign victim    = lru[fill_set];
   assign we0       = fill_done && !victim;
   assign we1       = fill_done && victim;

   assign i_mem_resp   = hit;
   assign i_rdata      = hit ? line_word(hit_way ? d1 : d0, req_word) : '0;
   assign pmem_read    = (state == FILL);
   assign pmem_address = (state == FILL) ? {fill_addr, 4'b0000} : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lru       <= '0;
         fill_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  lru[req_set] <= ~hit_way;
               end else if (i_read) begin
                  fill_addr <= {req_tag, req_set};
                  state     <= FILL;
               end
            end
            FILL: begin
               if (pmem_resp) begin
                  lru[fill_set] <= ~victim;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lc3b_icache.sv
// tb_lc3b_icache
//   Self-checking bench for lc3b_icache. The reference model keeps, per set,
//   the cached line addresses ordered most-recent-first (at most two) plus a
//   flag for an outstanding fill; line contents come from a random backing
//   memory. The bench also plays the memory, answering fills after 1..4 cycles.
module tb_lc3b_icache;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_read = 1'b0;
   logic [15:0]  i_address = '0;
   logic [15:0]  i_rdata;
   logic         i_mem_resp;
   logic         pmem_read;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_rdata = '0;
   logic         pmem_resp = 1'b0;

   always #5 clk = ~clk;

   lc3b_icache dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_rdata      (i_rdata),
      .i_mem_resp   (i_mem_resp),
      .pmem_read    (pmem_read),
      .pmem_address (pmem_address),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [127:0] mem [4096];        // backing store, indexed by line address
   logic [11:0]  recent [8][$];     // per set, most recently used first
   bit           pending = 0;
   logic [11:0]  fill_line = '0;
   int unsigned  wait_cnt = 0;
   int unsigned  next_delay = 0;    // 0: random fill latency

   function automatic int find_line(input logic [11:0] line);
      for (int i = 0; i < recent[line[2:0]].size(); i++)
         if (recent[line[2:0]][i] == line) return i;
      return -1;
   endfunction

   function automatic logic [15:0] mem_word(input logic [11:0] line, input logic [2:0] w);
      logic [127:0] l;
      l = mem[line];
      return l[16*w +: 16];
   endfunction

   task automatic model_clear();
      for (int s = 0; s < 8; s++) recent[s].delete();
      pending = 0;
   endtask

   // One clock cycle: drive at negedge, check 1 time unit later, then advance
   // the model to what the coming rising edge should produce.
   task automatic cycle(input logic rd, input logic [15:0] addr, input logic stray,
                        output logic was_hit);
      logic [11:0] line;
      logic [2:0]  s;
      int          pos;
      logic        exp_resp, do_resp;
      logic [15:0] exp_data;
      line = addr[15:4];
      s    = addr[6:4];
      @(negedge clk);
      i_read    = rd;
      i_address = addr;
      do_resp   = stray || (pending && wait_cnt == 1);
      pmem_resp = do_resp;
      pmem_rdata = (pending && do_resp) ? mem[fill_line]
                                        : {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (!pending) begin
         pos      = find_line(line);
         exp_resp = rd && (pos >= 0);
         exp_data = exp_resp ? mem_word(line, addr[3:1]) : 16'h0000;
         check("idle_pmem_read", {15'b0, pmem_read}, 16'h0000);
         check("idle_pmem_addr", pmem_address, 16'h0000);
      end else begin
         pos      = -1;
         exp_resp = 1'b0;
         exp_data = 16'h0000;
         check("fill_pmem_read", {15'b0, pmem_read}, 16'h0001);
         check("fill_pmem_addr", pmem_address, {fill_line, 4'h0});
      end
      check("i_mem_resp", {15'b0, i_mem_resp}, {15'b0, exp_resp});
      check("i_rdata", i_rdata, exp_data);
      was_hit = exp_resp;
      if (!pending) begin
         if (exp_resp) begin
            recent[s].delete(pos);
            recent[s].push_front(line);
         end else if (rd) begin
            pending   = 1;
            fill_line = line;
            wait_cnt  = (next_delay != 0) ? next_delay : $urandom_range(1, 4);
         end
      end else if (do_resp) begin
         recent[fill_line[2:0]].push_front(fill_line);
         if (recent[fill_line[2:0]].size() > 2) void'(recent[fill_line[2:0]].pop_back());
         pending = 0;
      end else begin
         wait_cnt--;
      end
   endtask

   // Request addr until it hits, bounded.
   task automatic access(input logic [15:0] addr);
      logic h;
      h = 0;
      for (int i = 0; i < 12 && !h; i++) cycle(1'b1, addr, 1'b0, h);
      if (!h) begin
         n_checks++;
         n_fail++;
         $display("FAIL access_timeout: addr %h got no hit expected hit within 12 cycles", addr);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      i_read    = 1'b0;
      pmem_resp = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("rst_pmem_read", {15'b0, pmem_read}, 16'h0000);
      check("rst_pmem_addr", pmem_address, 16'h0000);
      check("rst_i_mem_resp", {15'b0, i_mem_resp}, 16'h0000);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic h;
      logic [127:0] l;
      for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      l = mem[0];
      l[15:0] = 16'h1234;
      mem[0] = l;
      model_clear();

      // Reset state
      i_read = 1'b1;
      i_address = 16'h0000;
      #2;
      check("reset_i_mem_resp", {15'b0, i_mem_resp}, 16'h0000);
      check("reset_i_rdata", i_rdata, 16'h0000);
      check("reset_pmem_read", {15'b0, pmem_read}, 16'h0000);
      check("reset_pmem_addr", pmem_address, 16'h0000);
      i_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Cold miss with a 3-cycle fill, then hit on the fifth cycle
      next_delay = 3;
      for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0000, 1'b0, h);
      check("cold_hit_resp", {15'b0, h}, 16'h0001);
      check("cold_hit_data", i_rdata, 16'h1234);
      next_delay = 0;

      // Hit every word of the line
      for (int w = 0; w < 8; w++) cycle(1'b1, 16'(w * 2), 1'b0, h);

      // LRU eviction
      access(16'h0080);
      access(16'h0000);
      access(16'h0100);
      cycle(1'b1, 16'h0000, 1'b0, h);
      check("lru_keep_0000", {15'b0, i_mem_resp}, 16'h0001);
      cycle(1'b1, 16'h0080, 1'b0, h);
      check("lru_evict_0080", {15'b0, i_mem_resp}, 16'h0000);
      access(16'h0080);

      // Redirect during a fill
      next_delay = 4;
      cycle(1'b1, 16'h0200, 1'b0, h);
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0400, 1'b0, h);
      next_delay = 0;
      access(16'h0400);
      access(16'h0200);

      // Reset in the middle of a fill, stray response afterwards
      next_delay = 4;
      cycle(1'b1, 16'h0300, 1'b0, h);
      cycle(1'b1, 16'h0300, 1'b0, h);
      next_delay = 0;
      reset_pulse();
      cycle(1'b0, 16'h0300, 1'b1, h);
      cycle(1'b1, 16'h0300, 1'b0, h);
      check("post_reset_miss", {15'b0, i_mem_resp}, 16'h0000);
      access(16'h0300);

      // Odd byte address returns word 1
      access(16'h0003);
      check("odd_addr_word1", i_rdata, mem_word(12'h000, 3'd1));

      // Randomized traffic over a small address pool to force conflicts
      for (int i = 0; i < 1500; i++) begin
         logic [15:0] a;
         logic        rd, st;
         a  = {7'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 1)),
               3'($urandom), 1'($urandom)};
         rd = ($urandom_range(0, 7) != 0);
         st = !pending && ($urandom_range(0, 7) == 0);
         if (pending && $urandom_range(0, 199) == 0) reset_pulse();
         else cycle(rd, a, st, h);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
